// File: rtl/snake_pkg.sv
// Shared types, colour defaults and FSM encoding for the snake body engine.
package snake_pkg;

    localparam int unsigned COORD_W_DEF = 12;

    typedef logic [COORD_W_DEF-1:0] coord_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam rgb_t BODY_RGB_DEF = 24'h00FF00;
    localparam rgb_t HEAD_RGB_DEF = 24'hFFFF00;

    typedef enum logic [1:0] {StIdle, StCheck, StDone} state_e;

endpackage

// File: rtl/snake_body_engine_if.sv
// Move/grow handshake, VGA pixel query and status bundle of the snake body engine.
interface snake_body_engine_if #(
    parameter int unsigned COORD_W = 12,
    parameter int unsigned CNT_W   = 7
);
    logic               clear;
    logic [COORD_W-1:0] head_x;
    logic [COORD_W-1:0] head_y;
    logic               move_valid;
    logic               move_ready;
    logic               grow;
    logic [COORD_W-1:0] CounterX;
    logic [COORD_W-1:0] CounterY;
    logic [7:0]         vga_r;
    logic [7:0]         vga_g;
    logic [7:0]         vga_b;
    logic               pixel_hit;
    logic [CNT_W-1:0]   length;
    logic               collide;
    logic               check_done;

    modport master (
        output clear, head_x, head_y, move_valid, grow, CounterX, CounterY,
        input  move_ready, vga_r, vga_g, vga_b, pixel_hit, length, collide, check_done
    );

    modport slave (
        input  clear, head_x, head_y, move_valid, grow, CounterX, CounterY,
        output move_ready, vga_r, vga_g, vga_b, pixel_hit, length, collide, check_done
    );

endinterface

// File: rtl/snake_seg_render.sv
// Combinational pixel-vs-segment inclusion test with head priority flag.
module snake_seg_render #(
    parameter int unsigned COORD_W      = 12,
    parameter int unsigned SEG_SIZE     = 20,
    parameter int unsigned MAX_SEGMENTS = 64,
    parameter int unsigned CNT_W        = 7
) (
    input  logic [COORD_W-1:0] seg_x [MAX_SEGMENTS],
    input  logic [COORD_W-1:0] seg_y [MAX_SEGMENTS],
    input  logic [CNT_W-1:0]   length,
    input  logic [COORD_W-1:0] pix_x,
    input  logic [COORD_W-1:0] pix_y,
    output logic               hit,
    output logic               head_hit
);

    localparam logic [COORD_W:0] SIZE = (COORD_W+1)'(SEG_SIZE);

    // One extra bit keeps base+SIZE from wrapping near the screen edge.
    function automatic logic in_span(logic [COORD_W-1:0] base, logic [COORD_W-1:0] pos);
        return ({1'b0, pos} >= {1'b0, base}) && ({1'b0, pos} < ({1'b0, base} + SIZE));
    endfunction

    always_comb begin
        hit      = 1'b0;
        head_hit = 1'b0;
        for (int i = 0; i < MAX_SEGMENTS; i++) begin
            if ((CNT_W'(i) < length) && in_span(seg_x[i], pix_x) && in_span(seg_y[i], pix_y)) begin
                hit = 1'b1;
                if (i == 0) head_hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/snake_body_engine.sv
// Snake segment store: shift on move, pending growth, serial self-collision scan
// and one-cycle registered body/head rendering.
module snake_body_engine
    import snake_pkg::*;
#(
    parameter int unsigned COORD_W      = COORD_W_DEF,
    parameter int unsigned SEG_SIZE     = 20,
    parameter int unsigned MAX_SEGMENTS = 64,
    parameter int unsigned INIT_LEN     = 1,
    parameter int unsigned CNT_W        = $clog2(MAX_SEGMENTS + 1),
    parameter rgb_t        BODY_RGB     = BODY_RGB_DEF,
    parameter rgb_t        HEAD_RGB     = HEAD_RGB_DEF
) (
    input logic                CLOCK_50,
    input logic                reset_n,
    snake_body_engine_if.slave bus
);

    localparam int unsigned      IDX_W   = $clog2(MAX_SEGMENTS);
    localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(MAX_SEGMENTS);
    localparam logic [CNT_W-1:0] RST_LEN = CNT_W'(INIT_LEN);

    logic [COORD_W-1:0] seg_x_q [MAX_SEGMENTS];
    logic [COORD_W-1:0] seg_y_q [MAX_SEGMENTS];
    logic [CNT_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]   pend_q, pend_d, pend_grown;
    logic [IDX_W-1:0]   idx_q, idx_d;
    state_e             state_q, state_d;
    logic               move_acc, match, collide, check_done;
    logic               seg_hit, head_hit, pixel_hit_q;
    rgb_t               rgb_d, rgb_q;

    assign move_acc = bus.move_valid && (state_q == StIdle);
    assign match    = (seg_x_q[idx_q] == seg_x_q[0]) && (seg_y_q[idx_q] == seg_y_q[0]);

    always_comb begin
        pend_grown = pend_q;
        if (bus.grow && (pend_q != MAX_LEN)) pend_grown = pend_q + 1'b1;
        len_d      = len_q;
        pend_d     = pend_grown;
        idx_d      = idx_q;
        state_d    = state_q;
        collide    = 1'b0;
        check_done = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (move_acc) begin
                    // A grow arriving with the move is already folded into pend_grown.
                    if ((pend_grown != '0) && (len_q != MAX_LEN)) begin
                        len_d  = len_q + 1'b1;
                        pend_d = pend_grown - 1'b1;
                    end
                    idx_d   = IDX_W'(1);
                    state_d = (len_d != CNT_W'(1)) ? StCheck : StDone;
                end
            end
            StCheck: begin
                if (match) begin
                    collide = 1'b1;
                    state_d = StDone;
                end else if (CNT_W'(idx_q) == (len_q - 1'b1)) begin
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StDone: begin
                check_done = 1'b1;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            len_q   <= RST_LEN;
            pend_q  <= '0;
            idx_q   <= '0;
            for (int i = 0; i < MAX_SEGMENTS; i++) begin
                seg_x_q[i] <= '0;
                seg_y_q[i] <= '0;
            end
        end else if (bus.clear) begin
            state_q <= StIdle;
            len_q   <= RST_LEN;
            pend_q  <= '0;
            idx_q   <= '0;
            for (int i = 0; i < MAX_SEGMENTS; i++) begin
                seg_x_q[i] <= '0;
                seg_y_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            pend_q  <= pend_d;
            idx_q   <= idx_d;
            if (move_acc) begin
                for (int i = 1; i < MAX_SEGMENTS; i++) begin
                    seg_x_q[i] <= seg_x_q[i-1];
                    seg_y_q[i] <= seg_y_q[i-1];
                end
                seg_x_q[0] <= bus.head_x;
                seg_y_q[0] <= bus.head_y;
            end
        end
    end

    snake_seg_render #(
        .COORD_W      (COORD_W),
        .SEG_SIZE     (SEG_SIZE),
        .MAX_SEGMENTS (MAX_SEGMENTS),
        .CNT_W        (CNT_W)
    ) u_render (
        .seg_x    (seg_x_q),
        .seg_y    (seg_y_q),
        .length   (len_q),
        .pix_x    (bus.CounterX),
        .pix_y    (bus.CounterY),
        .hit      (seg_hit),
        .head_hit (head_hit)
    );

    always_comb begin
        rgb_d = '0;
        if (head_hit)     rgb_d = HEAD_RGB;
        else if (seg_hit) rgb_d = BODY_RGB;
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            pixel_hit_q <= 1'b0;
            rgb_q       <= '0;
        end else if (bus.clear) begin
            pixel_hit_q <= 1'b0;
            rgb_q       <= '0;
        end else begin
            pixel_hit_q <= seg_hit;
            rgb_q       <= rgb_d;
        end
    end

    assign bus.move_ready = (state_q == StIdle);
    assign bus.length     = len_q;
    assign bus.collide    = collide;
    assign bus.check_done = check_done;
    assign bus.pixel_hit  = pixel_hit_q;
    assign bus.vga_r      = rgb_q.r;
    assign bus.vga_g      = rgb_q.g;
    assign bus.vga_b      = rgb_q.b;

endmodule

// File: tb/tb_snake_body_engine.sv
// Bench for snake_body_engine: directed scenarios plus randomized moves against a queue model.
module tb_snake_body_engine;

    localparam int MAXS = 64;
    localparam int SEG  = 20;
    localparam logic [23:0] HEAD_C = 24'hFFFF00;
    localparam logic [23:0] BODY_C = 24'h00FF00;

    logic CLOCK_50 = 1'b0;
    logic reset_n  = 1'b0;
    int   n_assert = 0;
    int   n_fail   = 0;

    // Reference model: segment list, newest first, plus length and pending growth.
    int mx[$];
    int my[$];
    int m_len;
    int m_pend;

    always #10 CLOCK_50 = ~CLOCK_50;

    snake_body_engine_if #(.COORD_W(12), .CNT_W(7)) bus ();
    snake_body_engine_if #(.COORD_W(12), .CNT_W(3)) bus4 ();

    snake_body_engine #(.MAX_SEGMENTS(64)) dut (
        .CLOCK_50 (CLOCK_50),
        .reset_n  (reset_n),
        .bus      (bus)
    );

    snake_body_engine #(.MAX_SEGMENTS(4)) dut4 (
        .CLOCK_50 (CLOCK_50),
        .reset_n  (reset_n),
        .bus      (bus4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        mx.delete();
        my.delete();
        for (int i = 0; i < MAXS; i++) begin
            mx.push_back(0);
            my.push_back(0);
        end
        m_len  = 1;
        m_pend = 0;
    endtask

    // Advance one clock from a negedge; a grow seen at the edge is credited to the model.
    task automatic cycle();
        if (bus.grow === 1'b1 && m_pend < MAXS) m_pend++;
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
    endtask

    task automatic do_move(input int x, input int y, input bit g, input bit noisy);
        int exp_col, exp_done, got_col, got_done, ncol;
        check("move_ready_idle", 32'(bus.move_ready), 1);
        bus.head_x     = 12'(x);
        bus.head_y     = 12'(y);
        bus.move_valid = 1'b1;
        bus.grow       = g;
        if (g && m_pend < MAXS) m_pend++;
        mx.push_front(x);
        my.push_front(y);
        void'(mx.pop_back());
        void'(my.pop_back());
        if (m_pend > 0 && m_len < MAXS) begin
            m_len++;
            m_pend--;
        end
        exp_col = 0;
        for (int k = 1; k < m_len; k++)
            if (exp_col == 0 && mx[k] == x && my[k] == y) exp_col = k;
        exp_done = (exp_col != 0) ? exp_col + 1 : m_len;
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        bus.move_valid = 1'b0;
        bus.grow       = 1'b0;
        check("length_after_move", 32'(bus.length), m_len);
        got_col  = 0;
        got_done = 0;
        ncol     = 0;
        for (int c = 1; c <= MAXS + 4; c++) begin
            if (bus.collide === 1'b1) begin
                ncol++;
                if (got_col == 0) got_col = c;
            end
            if (bus.check_done === 1'b1) begin
                got_done = c;
                break;
            end
            check("move_ready_busy", 32'(bus.move_ready), 0);
            if (noisy) begin
                bus.grow       = ($urandom_range(0, 2) == 0);
                bus.move_valid = 1'($urandom_range(0, 1));
                bus.head_x     = 12'($urandom_range(0, 100));
                bus.head_y     = 12'($urandom_range(0, 40));
            end
            cycle();
        end
        bus.grow       = 1'b0;
        bus.move_valid = 1'b0;
        check("collide_cycle", got_col, exp_col);
        check("check_done_cycle", got_done, exp_done);
        check("collide_count", ncol, (exp_col != 0) ? 1 : 0);
        check("length_at_done", 32'(bus.length), m_len);
        cycle();
    endtask

    task automatic check_pixel(input int px, input int py);
        bit hit, head;
        logic [23:0] rgb;
        bus.CounterX = 12'(px);
        bus.CounterY = 12'(py);
        hit  = 1'b0;
        head = 1'b0;
        for (int i = 0; i < m_len; i++)
            if (px >= mx[i] && px < mx[i] + SEG && py >= my[i] && py < my[i] + SEG) begin
                hit = 1'b1;
                if (i == 0) head = 1'b1;
            end
        rgb = head ? HEAD_C : (hit ? BODY_C : 24'h0);
        cycle();
        check("pixel_hit", 32'(bus.pixel_hit), 32'(hit));
        check("pixel_rgb", 32'({bus.vga_r, bus.vga_g, bus.vga_b}), 32'(rgb));
    endtask

    initial begin
        bus.clear = 1'b0;  bus.head_x = '0;   bus.head_y = '0;   bus.move_valid = 1'b0;
        bus.grow = 1'b0;   bus.CounterX = '0; bus.CounterY = '0;
        bus4.clear = 1'b0; bus4.head_x = '0;  bus4.head_y = '0;  bus4.move_valid = 1'b0;
        bus4.grow = 1'b0;  bus4.CounterX = '0; bus4.CounterY = '0;
        m_reset();
        repeat (2) @(negedge CLOCK_50);
        reset_n = 1'b1;
        check("rst_length", 32'(bus.length), 1);
        check("rst_move_ready", 32'(bus.move_ready), 1);
        check("rst_collide", 32'(bus.collide), 0);
        check("rst_check_done", 32'(bus.check_done), 0);
        check("rst_pixel_hit", 32'(bus.pixel_hit), 0);
        check("rst_rgb", 32'({bus.vga_r, bus.vga_g, bus.vga_b}), 0);

        do_move(100, 40, 1'b0, 1'b0);
        check_pixel(105, 45);

        repeat (3) begin
            bus.grow = 1'b1;
            cycle();
        end
        bus.grow = 1'b0;
        do_move(0, 0, 1'b0, 1'b0);
        do_move(20, 0, 1'b0, 1'b0);
        do_move(40, 0, 1'b0, 1'b0);
        do_move(60, 0, 1'b0, 1'b0);
        check("len_after_growth", 32'(bus.length), 4);
        check_pixel(25, 5);

        // Grow together with a move, then walk a small square back onto seg[3].
        do_move(80, 0, 1'b1, 1'b0);
        do_move(80, 20, 1'b0, 1'b0);
        check("len_no_extra_pend", 32'(bus.length), 5);
        do_move(60, 20, 1'b0, 1'b0);
        do_move(80, 0, 1'b0, 1'b0);
        check_pixel(85, 5);

        bus.grow = 1'b1;
        cycle();
        bus.grow     = 1'b0;
        bus.clear    = 1'b1;
        bus.CounterX = 12'd85;
        bus.CounterY = 12'd5;
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        bus.clear = 1'b0;
        m_reset();
        check("clr_length", 32'(bus.length), 1);
        check("clr_move_ready", 32'(bus.move_ready), 1);
        check("clr_pixel_hit", 32'(bus.pixel_hit), 0);

        for (int n = 0; n < 40; n++) begin
            do_move(20 * int'($urandom_range(0, 4)), 20 * int'($urandom_range(0, 2)),
                    1'($urandom_range(0, 1)), 1'b1);
            check_pixel(int'($urandom_range(0, 110)), int'($urandom_range(0, 70)));
        end

        // Small store: growth saturates at capacity; far-right pixel must not wrap.
        for (int k = 0; k < 6; k++) begin
            bus4.grow = 1'b1;
            @(posedge CLOCK_50);
            @(negedge CLOCK_50);
        end
        bus4.grow = 1'b0;
        for (int k = 0; k < 6; k++) begin
            bus4.head_x     = 12'((k == 5) ? 4090 : 20 * k + 20);
            bus4.head_y     = 12'd0;
            bus4.move_valid = 1'b1;
            @(posedge CLOCK_50);
            @(negedge CLOCK_50);
            bus4.move_valid = 1'b0;
            check("cap_length", 32'(bus4.length), (k + 2 > 4) ? 4 : k + 2);
            for (int c = 0; c < 8 && bus4.check_done !== 1'b1; c++) begin
                @(posedge CLOCK_50);
                @(negedge CLOCK_50);
            end
            check("cap_check_done", 32'(bus4.check_done), 1);
            @(posedge CLOCK_50);
            @(negedge CLOCK_50);
        end
        bus4.CounterX = 12'd4095;
        bus4.CounterY = 12'd5;
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        check("edge_pixel_hit", 32'(bus4.pixel_hit), 1);
        check("edge_pixel_rgb", 32'({bus4.vga_r, bus4.vga_g, bus4.vga_b}), 32'(HEAD_C));
        bus4.CounterY = 12'd25;
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        check("edge_pixel_miss", 32'(bus4.pixel_hit), 0);

        // Reset in the middle of a scan.
        do_move(0, 40, 1'b1, 1'b0);
        bus.head_x     = 12'd100;
        bus.head_y     = 12'd40;
        bus.move_valid = 1'b1;
        bus.CounterX   = 12'd105;
        bus.CounterY   = 12'd45;
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        bus.move_valid = 1'b0;
        check("scan_busy", 32'(bus.move_ready), 0);
        reset_n = 1'b0;
        #1;
        check("abort_length", 32'(bus.length), 1);
        check("abort_move_ready", 32'(bus.move_ready), 1);
        check("abort_collide", 32'(bus.collide), 0);
        check("abort_check_done", 32'(bus.check_done), 0);
        check("abort_pixel_hit", 32'(bus.pixel_hit), 0);
        check("abort_rgb", 32'({bus.vga_r, bus.vga_g, bus.vga_b}), 0);
        repeat (3) begin
            @(posedge CLOCK_50);
            @(negedge CLOCK_50);
            check("abort_no_done", 32'(bus.check_done), 0);
        end
        reset_n = 1'b1;
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        check("post_abort_done", 32'(bus.check_done), 0);
        check("post_abort_length", 32'(bus.length), 1);
        check("post_abort_ready", 32'(bus.move_ready), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
